// File: rtl/grf_scoreboard.sv
// grf_scoreboard: D-stage read-after-write scoreboard for the P5 MIPS core.
// Holds a pending-write counter for each GPR. Issue of a GPR write bumps the
// counter, and the matching writeback drops it. A read of a register that
// still has writes outstanding stalls issue. Because the GRF cannot forward a
// same-cycle write to its read ports, this block forwards the writeback data
// onto the read operands itself.
module grf_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Issue_Valid,
  input  logic        Issue_We,
  input  logic [4:0]  Issue_Dst,
  input  logic        Src1_Use,
  input  logic [4:0]  Src1_Addr,
  input  logic        Src2_Use,
  input  logic [4:0]  Src2_Addr,
  input  logic [31:0] Grf_Rd1_In,
  input  logic [31:0] Grf_Rd2_In,
  input  logic        Wb_We,
  input  logic [4:0]  Wb_Addr,
  input  logic [31:0] Wb_Data,
  output logic        Stall_Out,
  output logic [31:0] Rd1_Out,
  output logic [31:0] Rd2_Out,
  output logic [31:0] Pending_Vec,
  output logic [6:0]  Inflight_Cnt,
  output logic        Err_Underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt [32];
  logic [31:0]      r_pending_vec;
  logic [6:0]       r_inflight_cnt;
  logic             r_err_underflow;

  logic [CNT_W-1:0] w_cnt_nxt [32];
  logic [31:0]      w_pending_nxt;
  logic [6:0]       w_inflight_nxt;
  logic [31:0]      w_inc_vec;
  logic [31:0]      w_dec_vec;

  logic [CNT_W-1:0] w_cnt_src1;
  logic [CNT_W-1:0] w_cnt_src2;
  logic [CNT_W-1:0] w_cnt_dst;
  logic [CNT_W-1:0] w_cnt_wb;
  logic             w_wb_hit_src1;
  logic             w_wb_hit_src2;
  logic             w_wb_hit_dst;
  logic             w_pend1_nz;
  logic             w_pend2_nz;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_full;
  logic             w_stall;
  logic             w_accept;
  logic             w_underflow;

  // Per-source hazard, full-counter and underflow detection.
  // A writeback landing this cycle retires one pending write, so it counts
  // as already done when deciding whether a source read must wait.
  always_comb begin
    w_cnt_src1    = r_cnt[Src1_Addr];
    w_cnt_src2    = r_cnt[Src2_Addr];
    w_cnt_dst     = r_cnt[Issue_Dst];
    w_cnt_wb      = r_cnt[Wb_Addr];
    w_wb_hit_src1 = Wb_We && (Wb_Addr == Src1_Addr) && (Src1_Addr != 5'd0);
    w_wb_hit_src2 = Wb_We && (Wb_Addr == Src2_Addr) && (Src2_Addr != 5'd0);
    w_wb_hit_dst  = Wb_We && (Wb_Addr == Issue_Dst) && (Issue_Dst != 5'd0);
    w_pend1_nz    = (w_cnt_src1 > CNT_ONE) || ((w_cnt_src1 == CNT_ONE) && !w_wb_hit_src1);
    w_pend2_nz    = (w_cnt_src2 > CNT_ONE) || ((w_cnt_src2 == CNT_ONE) && !w_wb_hit_src2);
    w_haz1        = Src1_Use && (Src1_Addr != 5'd0) && w_pend1_nz;
    w_haz2        = Src2_Use && (Src2_Addr != 5'd0) && w_pend2_nz;
    // A full counter can still take a new issue if writeback frees a slot now.
    w_full        = Issue_We && (Issue_Dst != 5'd0) && (w_cnt_dst == CNT_MAX) && !w_wb_hit_dst;
    w_stall       = Issue_Valid && (w_haz1 || w_haz2 || w_full);
    w_accept      = Issue_Valid && !w_stall;
    w_underflow   = Wb_We && (Wb_Addr != 5'd0) && (w_cnt_wb == '0);
  end

  // Increment and decrement requests for each tracked register.
  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    for (int r = 1; r < 32; r++) begin
      w_inc_vec[r] = w_accept && Issue_We && (Issue_Dst == 5'(r));
      w_dec_vec[r] = Wb_We && (Wb_Addr == 5'(r)) && (r_cnt[r] != '0);
    end
  end

  // Next counter values plus the derived pending bitmap and total in flight.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_cnt_nxt[0]   = '0;
    w_pending_nxt  = '0;
    w_inflight_nxt = '0;
    for (int r = 1; r < 32; r++) begin
      if (w_inc_vec[r] && !w_dec_vec[r]) begin
        w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
      end else if (w_dec_vec[r] && !w_inc_vec[r]) begin
        w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
      end
      w_pending_nxt[r] = (w_cnt_nxt[r] != '0);
      w_inflight_nxt   = w_inflight_nxt + 7'(w_cnt_nxt[r]);
    end
  end

  // State registers. Reset overrides any issue or writeback in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int r = 0; r < 32; r++) begin
        r_cnt[r] <= '0;
      end
      r_pending_vec   <= '0;
      r_inflight_cnt  <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      r_pending_vec  <= w_pending_nxt;
      r_inflight_cnt <= w_inflight_nxt;
      if (w_underflow) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  // Write-through bypass of the writeback data. $0 always reads as zero.
  always_comb begin
    if (Src1_Addr == 5'd0) begin
      Rd1_Out = '0;
    end else if (w_wb_hit_src1) begin
      Rd1_Out = Wb_Data;
    end else begin
      Rd1_Out = Grf_Rd1_In;
    end
    if (Src2_Addr == 5'd0) begin
      Rd2_Out = '0;
    end else if (w_wb_hit_src2) begin
      Rd2_Out = Wb_Data;
    end else begin
      Rd2_Out = Grf_Rd2_In;
    end
  end

  assign Stall_Out     = w_stall;
  assign Pending_Vec   = r_pending_vec;
  assign Inflight_Cnt  = r_inflight_cnt;
  assign Err_Underflow = r_err_underflow;

endmodule
